// File: rtl/stream_demux_pkg.sv
// Shared types for the packet-aware stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DISCARD
    } state_e;

    localparam int unsigned MAX_OUT = 16;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register for a single demux channel.
module demux_out_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    input  logic             i_out_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    output logic             o_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            // A load wins over a simultaneous drain: the slot stays full.
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_ready = !r_valid || i_out_ready;

endmodule

// File: rtl/stream_demux.sv
// Packet-aware 1-to-NUM_OUT demultiplexer: destination is latched on the first beat of a packet.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_OUT = 2,
    parameter int unsigned SEL_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_last,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]       out_last,
    output logic                     drop
);

    state_e             r_state;
    state_e             w_state_next;
    logic [SEL_W-1:0]   r_cur_ch;
    logic [SEL_W-1:0]   w_cur_ch_next;
    logic               r_drop;
    logic               w_drop_next;

    logic               w_sel_ok;
    logic [SEL_W-1:0]   w_target;
    logic               w_target_free;
    logic               w_routing;
    logic               w_accept;
    logic [NUM_OUT-1:0] w_load;
    logic [NUM_OUT-1:0] w_slot_ready;

    assign w_sel_ok = 32'(in_sel) < NUM_OUT;
    assign w_target = (r_state == IDLE) ? in_sel : r_cur_ch;

    always_comb begin
        w_target_free = 1'b0;
        for (int k = 0; k < int'(NUM_OUT); k++) begin
            if (w_target == SEL_W'(k)) w_target_free = w_slot_ready[k];
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cur_ch_next = r_cur_ch;
        w_drop_next   = 1'b0;
        w_routing     = 1'b0;
        in_ready      = 1'b0;
        case (r_state)
            IDLE: begin
                w_routing = w_sel_ok;
                in_ready  = w_sel_ok ? w_target_free : 1'b1;
            end
            ROUTE: begin
                w_routing = 1'b1;
                in_ready  = w_target_free;
            end
            DISCARD: in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
        if (rst) in_ready = 1'b0;
        w_accept = in_valid && in_ready;

        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (w_sel_ok) begin
                        w_cur_ch_next = in_sel;
                        w_state_next  = in_last ? IDLE : ROUTE;
                    end else begin
                        w_state_next = in_last ? IDLE : DISCARD;
                        w_drop_next  = in_last;
                    end
                end
                ROUTE: if (in_last) w_state_next = IDLE;
                DISCARD: begin
                    if (in_last) begin
                        w_state_next = IDLE;
                        w_drop_next  = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end

        w_load = '0;
        for (int k = 0; k < int'(NUM_OUT); k++) begin
            w_load[k] = w_accept && w_routing && (w_target == SEL_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cur_ch <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cur_ch <= w_cur_ch_next;
            r_drop   <= w_drop_next;
        end
    end

    assign drop = r_drop;

    for (genvar g = 0; g < int'(NUM_OUT); g++) begin : g_slot
        demux_out_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_load[g]),
            .i_data     (in_data),
            .i_last     (in_last),
            .i_out_ready(out_ready[g]),
            .o_valid    (out_valid[g]),
            .o_data     (out_data[g*WIDTH +: WIDTH]),
            .o_last     (out_last[g]),
            .o_ready    (w_slot_ready[g])
        );
    end

endmodule

// File: doc/stream_demux.md
# stream_demux

Packet-aware 1-to-NUM_OUT stream demultiplexer, the sequential inverse of the lab's 2:1 select path. It accepts one valid/ready input stream and latches the destination channel from `in_sel` on the first beat of each packet. It then steers every beat of that packet to the selected output through a one-entry register per channel. It sits between a single producer and NUM_OUT independent consumers; packets addressed to a nonexistent channel are consumed and discarded.

## Interface
- `WIDTH`, 8, data bits per beat.
- `NUM_OUT`, 2, number of output channels; 2..16, need not be a power of two.
- `SEL_W`, $clog2(NUM_OUT) (1 when NUM_OUT=2), width of `in_sel`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  input beat accepted this cycle when high with `in_valid`.
- `in_data`  in  WIDTH  beat payload.
- `in_last`  in  1  final beat of packet.
- `in_sel`  in  SEL_W  destination channel; sampled only on a packet's first beat.
- `out_valid`  out  NUM_OUT  per-channel beat present.
- `out_ready`  in  NUM_OUT  per-channel consumer ready.
- `out_data`  out  NUM_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `out_last`  out  NUM_OUT  per-channel last flag.
- `drop`  out  1  one-cycle pulse when a dropped packet's last beat is consumed.

## Operation
- FSM states: IDLE (awaiting first beat), ROUTE (packet locked to `cur_ch`), DISCARD (packet addressed out of range).
- In IDLE, the target is `in_sel`. In ROUTE, the target is `cur_ch`; `in_sel` is ignored.
- The target channel k is "free" when `!out_valid[k] || out_ready[k]`.
- `in_ready` rules:
  - in IDLE with `in_sel` < NUM_OUT, or in ROUTE: `in_ready` = target free;
  - in IDLE with `in_sel` >= NUM_OUT, or in DISCARD: `in_ready` = 1;
  - during `rst`: `in_ready` = 0.
- Accepted beat in IDLE with a valid `in_sel`:
  - load channel `in_sel` (data, last; valid set);
  - `cur_ch` <= `in_sel`;
  - next state ROUTE, or stay IDLE if `in_last`.
- Accepted beat in IDLE with an out-of-range `in_sel`: nothing written; go to DISCARD, or, if `in_last`, stay IDLE and pulse `drop`.
- Accepted beat in ROUTE: load `cur_ch`; on `in_last`, return to IDLE.
- Accepted beat in DISCARD: discard it; on `in_last`, pulse `drop` and return to IDLE.
- Output register k:
  - `out_valid[k]` clears when `out_valid[k] && out_ready[k]` and no new load;
  - a simultaneous drain and load keeps `out_valid[k]` = 1 with the new data.
- Non-target channels drain independently while a packet routes elsewhere.
- Reset mid-packet abandons the packet: state IDLE and all registers empty. Trailing beats after reset are treated as a new packet, sampling `in_sel` afresh.

## Timing
- Reset values: `out_valid` = 0, `out_last` = 0, `out_data` = 0, `drop` = 0, state IDLE, `cur_ch` = 0.
- Latency: an input accepted in cycle n appears on `out_*` in cycle n+1.
- Throughput: one beat per cycle to a channel whose consumer holds `out_ready` high.
- `in_ready` depends combinationally on `in_sel` (IDLE only) and on `out_ready`.
- `drop` is asserted in the cycle after the accepting edge.
- Once a packet locks, beats are never reordered or duplicated. Back-to-back packets to different channels incur no bubble.

## Structure
- A shared package `stream_demux_pkg` holds the state enum `{IDLE, ROUTE, DISCARD}` and `MAX_OUT = 16`.
- Sub-module `demux_out_slot` is a one-entry register: it takes load, data, and last in, and exposes valid, data, last, and ready. It is instantiated NUM_OUT times via generate.
- The top level holds the FSM, `cur_ch`, the in_ready mux, and drop generation.

## Test plan
- NUM_OUT=2, outputs always ready; 3-beat packet 0x11/0x22/0x33 with `in_sel` = 1 on beat 1 and `in_sel` = 0 on beats 2–3. Required: ch1 receives all three beats, each one cycle after acceptance, `out_last[1]` set only on 0x33, and `out_valid[0]` = 0 throughout.
- Backpressure: `out_ready[0]` = 0 for 4 cycles during a packet to ch0. Required: `in_ready` = 0 after the first held beat, no data loss, and the beat order resumes intact.
- Concurrency: ch1 holds a stalled beat while a single-beat packet (`in_last` = 1) routes to ch0. Required: ch0 accepts with no stall and ch1 keeps its data.
- NUM_OUT=3 with a 2-beat packet with `in_sel` = 3. Required: `in_ready` = 1 on both beats, no `out_valid`, and one `drop` pulse after beat 2.
- Assert `rst` for one cycle on beat 2 of a 4-beat packet. Required: all `out_valid` = 0 the next cycle, state IDLE, and the next accepted beat re-samples `in_sel`.
- Single-beat packets to alternating channels 0, 1, 0, 1 with all consumers ready. Required: one beat accepted every cycle, no idle cycles between packets.
